// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: load, stall-hold, flush-to-bubble,
// and forwarding of the execute stage's in-flight result into new operands.
module id_ex_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        rs1_used_i,
  input  logic        rs2_used_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_wen_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [31:0] ex_rd_data_i,
  input  logic        ex_rd_wen_i,
  input  logic        jump_en_i,
  input  logic        hold_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_wen_o,
  output logic        valid_o
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        rd_wen_q, rd_wen_d;
  logic        valid_q, valid_d;

  logic fwd1, fwd2;

  // x0 is hardwired to zero, so a result "written" to it must never forward.
  assign fwd1 = rs1_used_i & ex_rd_wen_i & (ex_rd_addr_i == rs1_addr_i) & (rs1_addr_i != 5'd0);
  assign fwd2 = rs2_used_i & ex_rd_wen_i & (ex_rd_addr_i == rs2_addr_i) & (rs2_addr_i != 5'd0);

  always_comb begin
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_addr_d   = rd_addr_q;
    rd_wen_d    = rd_wen_q;
    valid_d     = valid_q;
    if (jump_en_i) begin
      inst_d      = NOP_INST;
      inst_addr_d = 32'd0;
      op1_d       = 32'd0;
      op2_d       = 32'd0;
      rd_addr_d   = 5'd0;
      rd_wen_d    = 1'b0;
      valid_d     = 1'b0;
    end else if (!hold_i) begin
      inst_d      = inst_i;
      inst_addr_d = inst_addr_i;
      op1_d       = fwd1 ? ex_rd_data_i : op1_i;
      op2_d       = fwd2 ? ex_rd_data_i : op2_i;
      rd_addr_d   = rd_addr_i;
      rd_wen_d    = rd_wen_i;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q      <= NOP_INST;
      inst_addr_q <= 32'd0;
      op1_q       <= 32'd0;
      op2_q       <= 32'd0;
      rd_addr_q   <= 5'd0;
      rd_wen_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_addr_q   <= rd_addr_d;
      rd_wen_q    <= rd_wen_d;
      valid_q     <= valid_d;
    end
  end

  assign inst_o      = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_wen_o    = rd_wen_q;
  assign valid_o     = valid_q;

endmodule
